// File: rtl/vram_arbiter_pkg.sv
// Shared video timing constants, write payload type and arbiter state encoding
// for the VRAM port arbiter and its blanking-window decoder.
package vram_arbiter_pkg;

  localparam int unsigned AW        = 12;
  localparam int unsigned DW        = 8;
  localparam int unsigned HCNT_W    = 11;
  localparam int unsigned VCNT_W    = 10;

  localparam int unsigned H_ACT_LO  = 144;
  localparam int unsigned H_ACT_HI  = 783;
  localparam int unsigned V_ACT_LO  = 35;
  localparam int unsigned V_ACT_HI  = 514;
  localparam int unsigned GUARD     = 4;

  localparam int unsigned MAX_BURST = 8;
  localparam int unsigned BCNT_W    = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST_A = 2'd1,
    BURST_B = 2'd2
  } arb_state_e;

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } rr_ptr_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/vram_window_decode.sv
// Positional decode of the visible region and the write-safe blanking window
// from the horizontal/vertical timing counters.
module vram_window_decode
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned H_LO = H_ACT_LO,
  parameter int unsigned H_HI = H_ACT_HI,
  parameter int unsigned V_LO = V_ACT_LO,
  parameter int unsigned V_HI = V_ACT_HI,
  parameter int unsigned GRD  = GUARD
) (
  input  logic [HCNT_W-1:0] hcnt,
  input  logic [VCNT_W-1:0] vcnt,
  output logic              vis_c,
  output logic              open_c
);

  logic h_act;
  logic v_act;
  logic h_guard;

  assign h_act   = (hcnt >= HCNT_W'(H_LO)) && (hcnt <= HCNT_W'(H_HI));
  assign v_act   = (vcnt >= VCNT_W'(V_LO)) && (vcnt <= VCNT_W'(V_HI));
  // Guard band only matters on lines that will turn visible
  assign h_guard = (hcnt >= HCNT_W'(H_LO - GRD)) && (hcnt < HCNT_W'(H_LO));

  assign vis_c  = h_act && v_act;
  assign open_c = !vis_c && !(v_act && h_guard);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch owns the port while visible, writers
// A and B share blanking time in round-robin bursts of up to MAX_BURST words.
module vram_arbiter
  import vram_arbiter_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [HCNT_W-1:0] HCNT,
  input  logic [VCNT_W-1:0] VCNT,
  input  logic [AW-1:0]     DISP_ADDR,
  input  logic              REQ_A,
  input  logic [AW-1:0]     ADDR_A,
  input  logic [DW-1:0]     DATA_A,
  input  logic              REQ_B,
  input  logic [AW-1:0]     ADDR_B,
  input  logic [DW-1:0]     DATA_B,
  output logic              GNT_A,
  output logic              GNT_B,
  output logic [AW-1:0]     MEM_ADDR,
  output logic [DW-1:0]     MEM_WDATA,
  output logic              MEM_WE,
  output logic              MEM_RE,
  output logic              DISP_VALID
);

  logic              vis_c;
  logic              open_c;
  arb_state_e        state;
  arb_state_e        state_nxt;
  rr_ptr_e           ptr;
  rr_ptr_e           ptr_nxt;
  rr_ptr_e           ptr_other;
  logic [BCNT_W-1:0] bcnt;
  logic [BCNT_W-1:0] bcnt_nxt;
  logic [BCNT_W-1:0] bcnt_inc;
  logic              req_cur;
  logic              gnt_a_c;
  logic              gnt_b_c;
  wr_req_t           wr_a;
  wr_req_t           wr_b;
  wr_req_t           wr_sel;

  vram_window_decode u_decode (
    .hcnt   (HCNT),
    .vcnt   (VCNT),
    .vis_c  (vis_c),
    .open_c (open_c)
  );

  assign wr_a      = {ADDR_A, DATA_A};
  assign wr_b      = {ADDR_B, DATA_B};
  assign wr_sel    = gnt_a_c ? wr_a : wr_b;
  assign bcnt_inc  = bcnt + BCNT_W'(1);
  assign ptr_other = (state == BURST_A) ? PTR_B : PTR_A;

  // Arbiter state, round-robin pointer and burst length
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      ptr   <= PTR_A;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    bcnt_nxt  = bcnt;
    req_cur   = 1'b0;
    gnt_a_c   = 1'b0;
    gnt_b_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (open_c && (REQ_A || REQ_B)) begin
          bcnt_nxt = '0;
          if (ptr == PTR_A) state_nxt = REQ_A ? BURST_A : BURST_B;
          else              state_nxt = REQ_B ? BURST_B : BURST_A;
        end
      end
      BURST_A, BURST_B: begin
        req_cur = (state == BURST_A) ? REQ_A : REQ_B;
        if (open_c && req_cur) begin
          gnt_a_c  = (state == BURST_A);
          gnt_b_c  = (state == BURST_B);
          bcnt_nxt = bcnt_inc;
          if (bcnt_inc == BCNT_W'(MAX_BURST)) begin
            state_nxt = IDLE;
            ptr_nxt   = ptr_other;
          end
        end else begin
          // Window closed or writer dropped out: hand the next turn over
          state_nxt = IDLE;
          ptr_nxt   = ptr_other;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign GNT_A = gnt_a_c;
  assign GNT_B = gnt_b_c;

  // VRAM pin drive: a granted write wins, otherwise display fetch when visible
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      MEM_WE     <= 1'b0;
      MEM_RE     <= 1'b0;
      DISP_VALID <= 1'b0;
    end else begin
      DISP_VALID <= MEM_RE;
      if (gnt_a_c || gnt_b_c) begin
        MEM_WE    <= 1'b1;
        MEM_RE    <= 1'b0;
        MEM_ADDR  <= wr_sel.addr;
        MEM_WDATA <= wr_sel.data;
      end else if (vis_c) begin
        MEM_WE   <= 1'b0;
        MEM_RE   <= 1'b1;
        MEM_ADDR <= DISP_ADDR;
      end else begin
        MEM_WE <= 1'b0;
        MEM_RE <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed window/burst/reset scenarios plus
// randomized lines, checked against a behavioural arbitration model.
module tb_vram_arbiter;

  logic        CLK;
  logic        RST_N;
  logic [10:0] HCNT;
  logic [9:0]  VCNT;
  logic [11:0] DISP_ADDR;
  logic        REQ_A, REQ_B;
  logic [11:0] ADDR_A, ADDR_B;
  logic [7:0]  DATA_A, DATA_B;
  logic        GNT_A, GNT_B;
  logic [11:0] MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic        MEM_WE, MEM_RE, DISP_VALID;

  vram_arbiter dut (
    .CLK(CLK), .RST_N(RST_N), .HCNT(HCNT), .VCNT(VCNT), .DISP_ADDR(DISP_ADDR),
    .REQ_A(REQ_A), .ADDR_A(ADDR_A), .DATA_A(DATA_A),
    .REQ_B(REQ_B), .ADDR_B(ADDR_B), .DATA_B(DATA_B),
    .GNT_A(GNT_A), .GNT_B(GNT_B), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_WE(MEM_WE), .MEM_RE(MEM_RE), .DISP_VALID(DISP_VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    bit         is_wr;
    logic [11:0] addr;
    logic [7:0]  data;
  } txn_t;

  txn_t       txq[$];
  logic [1:0] gq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_due = -1;
  int ga_cnt = 0, gb_cnt = 0;
  int m_ga = 0, m_gb = 0;
  bit mon_en = 1'b0;
  bit want_a = 1'b0, want_b = 1'b0;
  bit pend_a = 1'b0, pend_b = 1'b0;
  bit adv_a = 1'b0, adv_b = 1'b0;

  // Reference arbitration state: current burst owner (-1 none), turn, words served
  int m_owner = -1;
  int m_ptr = 0;
  int m_served = 0;

  function automatic bit f_vis(input int h, input int v);
    return (h >= 144) && (h <= 783) && (v >= 35) && (v <= 514);
  endfunction

  function automatic bit f_open(input int h, input int v);
    return !f_vis(h, v) && !((v >= 35) && (v <= 514) && (h >= 140) && (h <= 143));
  endfunction

  // Returns the writer granted this cycle (0=A, 1=B, -1=none)
  function automatic int model_cycle(input bit ra, input bit rb, input int h, input int v);
    bit r[2];
    int g;
    r[0] = ra;
    r[1] = rb;
    g = -1;
    if (m_owner < 0) begin
      if (f_open(h, v) && (ra || rb)) begin
        m_owner  = r[m_ptr] ? m_ptr : 1 - m_ptr;
        m_served = 0;
      end
    end else if (f_open(h, v) && r[m_owner]) begin
      g = m_owner;
      m_served++;
      if (m_served == 8) begin
        m_ptr   = 1 - m_owner;
        m_owner = -1;
      end
    end else begin
      m_ptr   = 1 - m_owner;
      m_owner = -1;
    end
    return g;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d h=%0d v=%0d got=%0h exp=%0h", name, cyc, HCNT, VCNT, got, exp);
    end
  endtask

  task automatic step(input int h, input int v);
    int g;
    txn_t t;
    @(posedge CLK);
    #1;
    cyc++;
    if (adv_a) begin ADDR_A = 12'($urandom); DATA_A = 8'($urandom); adv_a = 1'b0; end
    if (adv_b) begin ADDR_B = 12'($urandom); DATA_B = 8'($urandom); adv_b = 1'b0; end
    REQ_A = want_a | pend_a;
    REQ_B = want_b | pend_b;
    HCNT = 11'(h);
    VCNT = 10'(v);
    DISP_ADDR = 12'($urandom);
    g = model_cycle(REQ_A, REQ_B, h, v);
    gq.push_back({g == 0, g == 1});
    t.cyc = cyc + 1;
    if (g == 0) begin
      t.is_wr = 1'b1; t.addr = ADDR_A; t.data = DATA_A;
      txq.push_back(t); adv_a = 1'b1; m_ga++;
    end else if (g == 1) begin
      t.is_wr = 1'b1; t.addr = ADDR_B; t.data = DATA_B;
      txq.push_back(t); adv_b = 1'b1; m_gb++;
    end else if (f_vis(h, v)) begin
      t.is_wr = 1'b0; t.addr = DISP_ADDR; t.data = 8'h0;
      txq.push_back(t);
    end
    pend_a = REQ_A && (g != 0);
    pend_b = REQ_B && (g != 1);
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  // Let outstanding requests finish in vertical blanking, then idle the arbiter
  task automatic drain();
    int i;
    want_a = 1'b0;
    want_b = 1'b0;
    i = 0;
    while ((pend_a || pend_b) && i < 40) begin
      step(200 + i, 520);
      i++;
    end
    chk("drain_timeout", 32'(pend_a || pend_b), 32'd0);
    step(300, 520);
    step(301, 520);
  endtask

  // Monitor: compare grants every cycle and port activity as it appears
  always @(negedge CLK) begin : mon
    logic [1:0] eg;
    txn_t t;
    bit has;
    if (mon_en) begin
      if (gq.size() > 0) begin
        eg = gq.pop_front();
        chk("gnt", {30'd0, GNT_A, GNT_B}, {30'd0, eg});
      end
      if (GNT_A) ga_cnt++;
      if (GNT_B) gb_cnt++;
      if (GNT_A || GNT_B) begin
        chk("gnt_both", 32'(GNT_A && GNT_B), 32'd0);
        chk("gnt_window", 32'(f_open(int'(HCNT), int'(VCNT))), 32'd1);
      end
      if (MEM_WE || MEM_RE) chk("we_re_excl", 32'(MEM_WE && MEM_RE), 32'd0);
      chk("disp_valid", 32'(DISP_VALID), 32'(dv_due == cyc));
      has = (txq.size() > 0) && (txq[0].cyc == cyc);
      if (has) begin
        t = txq.pop_front();
        chk("port_we", 32'(MEM_WE), 32'(t.is_wr));
        chk("port_re", 32'(MEM_RE), 32'(!t.is_wr));
        chk("port_addr", 32'(MEM_ADDR), 32'(t.addr));
        if (t.is_wr) chk("port_wdata", 32'(MEM_WDATA), 32'(t.data));
        else dv_due = cyc + 1;
      end else if (MEM_WE || MEM_RE) begin
        chk("port_unexpected", {30'd0, MEM_WE, MEM_RE}, 32'd0);
      end
    end
  end

  initial begin
    int ga0, gb0, gb1, gb2, base, i, v;
    RST_N = 1'b0;
    HCNT = '0; VCNT = '0; DISP_ADDR = '0;
    REQ_A = 1'b0; REQ_B = 1'b0;
    ADDR_A = 12'($urandom); DATA_A = 8'($urandom);
    ADDR_B = 12'($urandom); DATA_B = 8'($urandom);
    #2;
    chk("reset_outputs", {7'd0, GNT_A, GNT_B, MEM_WE, MEM_RE, DISP_VALID, MEM_ADDR, MEM_WDATA}, 32'd0);
    #21;
    RST_N = 1'b1;
    mon_en = 1'b1;

    // Display fetch starts exactly at the first visible pixel
    for (int h = 0; h < 832; h++) step(h, 0);
    for (int h = 0; h < 832; h++) step(h, 34);
    for (int h = 0; h <= 150; h++) step(h, 35);

    // Single writer burst capped at MAX_BURST, then the pointer favours B
    ga0 = ga_cnt;
    base = m_ga;
    want_a = 1'b1;
    for (int h = 790; h < 832 && (m_ga - base) < 8; h++) step(h, 100);
    want_a = 1'b0;
    step(820, 100);
    step(821, 100);
    settle();
    chk("burst_a_len", 32'(ga_cnt - ga0), 32'd8);
    gb0 = gb_cnt;
    want_a = 1'b1;
    want_b = 1'b1;
    step(822, 100);
    step(823, 100);
    settle();
    chk("ptr_flip_b_first", 32'(gb_cnt - gb0), 32'd1);
    drain();

    // Request just before the guard band: blocked through the visible line
    want_b = 1'b1;
    gb0 = gb_cnt;
    for (int h = 138; h <= 139; h++) step(h, 100);
    settle();
    gb1 = gb_cnt;
    for (int h = 140; h <= 783; h++) step(h, 100);
    settle();
    gb2 = gb_cnt;
    for (int h = 784; h <= 800; h++) step(h, 100);
    settle();
    chk("pre_guard_gnts_le2", 32'((gb1 - gb0) >= 1 && (gb1 - gb0) <= 2), 32'd1);
    chk("guard_vis_gnts", 32'(gb2 - gb1), 32'd0);
    chk("resume_after_vis", 32'(gb_cnt > gb2), 32'd1);
    drain();

    // Reset pulsed in the middle of an A burst
    want_a = 1'b1;
    base = m_ga;
    i = 0;
    while ((m_ga - base) < 3 && i < 20) begin
      step(400 + i, 520);
      i++;
    end
    chk("reset_setup_timeout", 32'(m_ga - base), 32'd3);
    step(430, 520);
    #2;
    chk("pre_reset_gnt_a", 32'(GNT_A), 32'd1);
    chk("pre_reset_we", 32'(MEM_WE), 32'd1);
    mon_en = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("rst_async_we", 32'(MEM_WE), 32'd0);
    chk("rst_async_gnt_a", 32'(GNT_A), 32'd0);
    chk("rst_async_dv", 32'(DISP_VALID), 32'd0);
    gq.delete();
    txq.delete();
    m_owner = -1; m_ptr = 0; m_served = 0; dv_due = -1;
    want_a = 1'b0; pend_a = 1'b0; pend_b = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RST_N = 1'b1;
    mon_en = 1'b1;

    // Both writers from reset: A's full burst strictly before B's
    ga0 = ga_cnt;
    gb0 = gb_cnt;
    want_a = 1'b1;
    want_b = 1'b1;
    for (int h = 100; h < 118; h++) step(h, 520);
    settle();
    chk("both_a_burst", 32'(ga_cnt - ga0), 32'd8);
    chk("both_b_burst", 32'(gb_cnt - gb0), 32'd8);
    drain();

    // Randomized requests over visible and blanking lines
    for (int l = 0; l < 24; l++) begin
      if ($urandom_range(0, 1) == 1) v = 35 + 7 * int'($urandom_range(0, 68));
      else if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 34));
      else v = int'($urandom_range(515, 524));
      for (int h = 0; h < 832; h++) begin
        want_a = ($urandom_range(0, 3) != 0);
        want_b = ($urandom_range(0, 3) != 0);
        step(h, v);
      end
    end
    drain();
    settle();
    chk("scoreboard_empty", 32'(txq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
